// File: rtl/sensor_display_scan_pkg.sv
// Shared constants and types for the sensor display path.
package sensor_display_scan_pkg;

  // Symbol codes understood by the downstream 7-segment decoder
  localparam logic [3:0] SYM_DEG = 4'd10;
  localparam logic [3:0] SYM_R   = 4'd11;
  localparam logic [3:0] SYM_H   = 4'd12;
  localparam logic [3:0] SYM_C   = 4'd13;
  localparam logic [3:0] SYM_F   = 4'd14;

  // Slot index == anode bit position; slot 3 is the leftmost digit
  localparam logic [1:0] SLOT_UNIT = 2'd0;
  localparam logic [1:0] SLOT_SYM  = 2'd1;
  localparam logic [1:0] SLOT_ONES = 2'd2;
  localparam logic [1:0] SLOT_TENS = 2'd3;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/sensor_display_scan_bin_to_bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, VALUE_W steps.
// Inputs are pre-clamped to 0..99 so a two-nibble accumulator suffices.
module bin_to_bcd_seq #(
  parameter int VALUE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VALUE_W-1:0] din,
  output logic               done,
  output logic [3:0]         tens,
  output logic [3:0]         ones
);
  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0] sr;
  logic [7:0]         acc;
  logic [7:0]         adj;
  logic [7+VALUE_W:0] sh;
  logic [CNT_W-1:0]   cnt;
  logic               run;

  // Add 3 to every nibble >= 5, then shift the accumulator/shift-reg pair left
  always_comb begin
    adj[3:0] = (acc[3:0] >= 4'd5) ? acc[3:0] + 4'd3 : acc[3:0];
    adj[7:4] = (acc[7:4] >= 4'd5) ? acc[7:4] + 4'd3 : acc[7:4];
    sh       = {adj, sr} << 1;
  end

  // Step counter and datapath; done pulses for one cycle after the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr  <= din;
        acc <= '0;
        cnt <= CNT_W'(VALUE_W);
        run <= 1'b1;
      end else if (run) begin
        acc <= sh[7+VALUE_W:VALUE_W];
        sr  <= sh[VALUE_W-1:0];
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign tens = acc[7:4];
  assign ones = acc[3:0];

endmodule

// File: rtl/sensor_display_scan.sv
// Sensor reading -> two BCD digits + unit symbols, scanned onto a shared
// code bus with active-low anodes.
module sensor_display_scan
  import sensor_display_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int VALUE_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  input  logic               mode,
  input  logic               unit_f,
  output logic [3:0]         bcd,
  output logic [3:0]         an,
  output logic               busy
);
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  conv_state_t        state, state_nx;
  logic [VALUE_W-1:0] in_clamped, pend_val, start_val;
  logic               pend_vld, pend_mode, pend_unit;
  logic               start, start_mode, start_unit, commit;
  logic               cap_mode, cap_unit;
  logic               conv_done;
  logic [3:0]         conv_tens, conv_ones;
  logic [3:0]         tens, ones;
  logic               disp_mode, disp_unit;
  logic [REF_W-1:0]   rcnt;
  logic [1:0]         slot;
  logic               tick;
  logic [3:0]         slot_an, slot_bcd;

  // Readings above 99 are shown as 99 so the tens digit stays a decimal digit
  always_comb begin
    in_clamped = (32'(value) > 32'd99) ? VALUE_W'(99) : value;
  end

  bin_to_bcd_seq #(.VALUE_W(VALUE_W)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (start_val),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  // Conversion state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state and start selection; a strobe in DONE beats any pending entry
  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    commit     = 1'b0;
    start_val  = in_clamped;
    start_mode = mode;
    start_unit = unit_f;
    case (state)
      ST_IDLE: begin
        if (value_valid) begin
          start    = 1'b1;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (conv_done) state_nx = ST_DONE;
      end
      ST_DONE: begin
        commit = 1'b1;
        if (value_valid || pend_vld) begin
          start    = 1'b1;
          state_nx = ST_SHIFT;
          if (!value_valid) begin
            start_val  = pend_val;
            start_mode = pend_mode;
            start_unit = pend_unit;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // One-deep pending buffer (last strobe wins), capture and display commit
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_val  <= '0;
      pend_mode <= 1'b0;
      pend_unit <= 1'b0;
      cap_mode  <= 1'b0;
      cap_unit  <= 1'b0;
      tens      <= '0;
      ones      <= '0;
      disp_mode <= 1'b0;
      disp_unit <= 1'b0;
    end else begin
      if (state == ST_DONE) begin
        pend_vld <= 1'b0;
      end else if (state == ST_SHIFT && value_valid) begin
        pend_vld  <= 1'b1;
        pend_val  <= in_clamped;
        pend_mode <= mode;
        pend_unit <= unit_f;
      end
      if (start) begin
        cap_mode <= start_mode;
        cap_unit <= start_unit;
      end
      if (commit) begin
        tens      <= conv_tens;
        ones      <= conv_ones;
        disp_mode <= cap_mode;
        disp_unit <= cap_unit;
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign tick = (rcnt == REF_W'(REFRESH_DIV - 1));

  // Code/anode pattern for the slot about to be shown
  always_comb begin
    slot_an  = AN_OFF;
    slot_bcd = 4'd0;
    case (slot)
      SLOT_TENS: begin
        if (tens != 4'd0) begin
          slot_an  = 4'b0111;
          slot_bcd = tens;
        end
      end
      SLOT_ONES: begin
        slot_an  = 4'b1011;
        slot_bcd = ones;
      end
      SLOT_SYM: begin
        slot_an  = 4'b1101;
        slot_bcd = disp_mode ? SYM_R : SYM_DEG;
      end
      default: begin
        slot_an  = 4'b1110;
        slot_bcd = disp_mode ? SYM_H : (disp_unit ? SYM_F : SYM_C);
      end
    endcase
  end

  // Refresh divider and slot rotation; outputs only move on a tick
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
      slot <= 2'd0;
      bcd  <= 4'd0;
      an   <= AN_OFF;
    end else begin
      rcnt <= tick ? '0 : rcnt + REF_W'(1);
      if (tick) begin
        bcd  <= slot_bcd;
        an   <= slot_an;
        slot <= slot + 2'd1;
      end
    end
  end

endmodule
